// File: rtl/alu_exec_pipe_if.sv
// Decoded-op IDs and the RS/CDB handshake bundle for alu_exec_pipe.
// The ID values mirror the decoder's Inst* enumeration.
package alu_exec_pkg;
  localparam int Instlui    = 1;
  localparam int Instauipc  = 2;
  localparam int Instjal    = 3;
  localparam int Instjalr   = 4;
  localparam int Instbeq    = 5;
  localparam int Instbne    = 6;
  localparam int Instblt    = 7;
  localparam int Instbge    = 8;
  localparam int Instbltu   = 9;
  localparam int Instbgeu   = 10;
  localparam int Instaddi   = 11;
  localparam int Instslti   = 12;
  localparam int Instsltiu  = 13;
  localparam int Instxori   = 14;
  localparam int Instori    = 15;
  localparam int Instandi   = 16;
  localparam int Instslli   = 17;
  localparam int Instsrli   = 18;
  localparam int Instsrai   = 19;
  localparam int Instadd    = 20;
  localparam int Instsub    = 21;
  localparam int Instsll    = 22;
  localparam int Instslt    = 23;
  localparam int Instsltu   = 24;
  localparam int Instxor    = 25;
  localparam int Instsrl    = 26;
  localparam int Instsra    = 27;
  localparam int Instor     = 28;
  localparam int Instand    = 29;
  localparam int Instmul    = 30;
  localparam int Instmulh   = 31;
  localparam int Instmulhsu = 32;
  localparam int Instmulhu  = 33;
endpackage

interface alu_exec_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_npc;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_result;
  logic [XLEN-1:0]  out_npc;
  logic             out_jump;

  modport slave (
    input  in_valid, in_op, in_npc,
    input  in_rs1, in_rs2, in_imm,
    input  in_tag, out_ready,
    output in_ready, out_valid,
    output out_tag, out_result,
    output out_npc, out_jump
  );

  modport master (
    output in_valid, in_op, in_npc,
    output in_rs1, in_rs2, in_imm,
    output in_tag, out_ready,
    input  in_ready, out_valid,
    input  out_tag, out_result,
    input  out_npc, out_jump
  );
endinterface

// File: rtl/alu_exec_pipe.sv
// Registered ALU between RS and CDB with valid/ready, flush and redirect.
// Define ALU_MUL_EN to add the iterative RV32M multiplier.
module alu_exec_pipe
  import alu_exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 6
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic flush,
  alu_exec_if.slave bus
);
  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             vld_q, vld_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [XLEN-1:0]  npc_q, npc_d;
  logic             jmp_q, jmp_d;

  logic [XLEN-1:0]  a, b, imm;
  logic [XLEN-1:0]  pc, tgt, jsum;
  logic [XLEN-1:0]  res, nxt;
  logic [SH_W-1:0]  shi, shr;
  logic             is_mul, jmp;
  logic             xfer, accept;

  assign a    = bus.in_rs1;
  assign b    = bus.in_rs2;
  assign imm  = bus.in_imm;
  assign pc   = bus.in_npc - XLEN'(4);
  assign tgt  = pc + imm;
  assign jsum = a + imm;
  assign shi  = imm[SH_W-1:0];
  assign shr  = b[SH_W-1:0];

  always_comb begin
    res    = '0;
    nxt    = bus.in_npc;
    is_mul = 1'b0;
    unique case (bus.in_op)
      OP_W'(Instlui):   res = imm;
      OP_W'(Instauipc): res = tgt;
      OP_W'(Instjal): begin
        res = bus.in_npc;
        nxt = tgt;
      end
      OP_W'(Instjalr): begin
        res = bus.in_npc;
        nxt = {jsum[XLEN-1:1], 1'b0};
      end
      OP_W'(Instbeq):
        if (a == b) nxt = tgt;
      OP_W'(Instbne):
        if (a != b) nxt = tgt;
      OP_W'(Instblt):
        if ($signed(a) < $signed(b)) nxt = tgt;
      OP_W'(Instbge):
        if ($signed(a) >= $signed(b)) nxt = tgt;
      OP_W'(Instbltu):
        if (a < b) nxt = tgt;
      OP_W'(Instbgeu):
        if (a >= b) nxt = tgt;
      OP_W'(Instaddi): res = a + imm;
      OP_W'(Instslti):
        res = XLEN'($signed(a) < $signed(imm));
      OP_W'(Instsltiu): res = XLEN'(a < imm);
      OP_W'(Instxori):  res = a ^ imm;
      OP_W'(Instori):   res = a | imm;
      OP_W'(Instandi):  res = a & imm;
      OP_W'(Instslli):  res = a << shi;
      OP_W'(Instsrli):  res = a >> shi;
      OP_W'(Instsrai):
        res = XLEN'($signed(a) >>> shi);
      OP_W'(Instadd):   res = a + b;
      OP_W'(Instsub):   res = a - b;
      OP_W'(Instsll):   res = a << shr;
      OP_W'(Instslt):
        res = XLEN'($signed(a) < $signed(b));
      OP_W'(Instsltu):  res = XLEN'(a < b);
      OP_W'(Instxor):   res = a ^ b;
      OP_W'(Instsrl):   res = a >> shr;
      OP_W'(Instsra):
        res = XLEN'($signed(a) >>> shr);
      OP_W'(Instor):    res = a | b;
      OP_W'(Instand):   res = a & b;
`ifdef ALU_MUL_EN
      OP_W'(Instmul),
      OP_W'(Instmulh),
      OP_W'(Instmulhsu),
      OP_W'(Instmulhu): is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  assign jmp = (nxt != bus.in_npc);

  assign bus.in_ready = rdy_in & ~flush
                      & (state_q == IDLE)
                      & (~vld_q | bus.out_ready);

  assign xfer   = vld_q & bus.out_ready;
  assign accept = bus.in_valid & bus.in_ready;

`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] mc_q, mc_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] add;
  logic [XLEN-1:0]   mp_q, mp_d;
  logic [SH_W:0]     cnt_q, cnt_d;
  logic              sb_q, sb_d;
  logic              hi_q, hi_d;
  logic              sa;

  assign sa  = (bus.in_op == OP_W'(Instmulh))
             | (bus.in_op == OP_W'(Instmulhsu));
  assign add = mp_q[0] ? mc_q : '0;
`endif

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    tag_d   = tag_q;
    res_d   = res_q;
    npc_d   = npc_q;
    jmp_d   = jmp_q;
`ifdef ALU_MUL_EN
    mc_d  = mc_q;
    acc_d = acc_q;
    mp_d  = mp_q;
    cnt_d = cnt_q;
    sb_d  = sb_q;
    hi_d  = hi_q;
`endif
    if (xfer) vld_d = 1'b0;
    if (accept) begin
      tag_d = bus.in_tag;
      npc_d = nxt;
      jmp_d = jmp;
      if (!is_mul) begin
        vld_d = 1'b1;
        res_d = res;
      end
    end
`ifdef ALU_MUL_EN
    if (accept && is_mul) begin
      state_d = MUL;
      mc_d  = {{XLEN{sa & a[XLEN-1]}}, a};
      mp_d  = b;
      acc_d = '0;
      cnt_d = '0;
      sb_d  = (bus.in_op == OP_W'(Instmulh));
      hi_d  = (bus.in_op != OP_W'(Instmul));
    end
    unique case (state_q)
      MUL: begin
        if (cnt_q == (SH_W+1)'(XLEN)) begin
          res_d   = hi_q ? acc_q[2*XLEN-1:XLEN]
                         : acc_q[XLEN-1:0];
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          // signed multiplier: top bit carries weight -2^(XLEN-1)
          if (sb_q && cnt_q == (SH_W+1)'(XLEN-1))
            acc_d = acc_q - add;
          else
            acc_d = acc_q + add;
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:
        if (xfer) state_d = IDLE;
      default: ;
    endcase
`endif
    if (flush) begin
      vld_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      npc_q   <= '0;
      jmp_q   <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      npc_q   <= npc_d;
      jmp_q   <= jmp_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mc_q  <= '0;
      acc_q <= '0;
      mp_q  <= '0;
      cnt_q <= '0;
      sb_q  <= 1'b0;
      hi_q  <= 1'b0;
    end else if (rdy_in) begin
      mc_q  <= mc_d;
      acc_q <= acc_d;
      mp_q  <= mp_d;
      cnt_q <= cnt_d;
      sb_q  <= sb_d;
      hi_q  <= hi_d;
    end
  end
`endif

  assign bus.out_valid  = vld_q;
  assign bus.out_tag    = tag_q;
  assign bus.out_result = res_q;
  assign bus.out_npc    = npc_q;
  assign bus.out_jump   = jmp_q;
endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Parametrised, registered successor to the combinational ALU between the RS and the CDB.
- Accepts one decoded instruction per cycle via valid/ready and produces a registered result, tag and resolved next-PC.
- Adds backpressure, ROB flush, a jump-redirect flag and corrected unsigned/logical semantics.
- Optionally adds an iterative RV32M multiplier.

Parameters:
XLEN, 32, datapath width for operands, immediate, result and PC
TAG_W, 4, ROB tag width
OP_W, 6, width of the decoded instruction ID (the decoder's Inst* enumeration)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global enable; 0 freezes all state
in_valid  input  1  RS presents an instruction
in_ready  output  1  unit accepts this cycle
in_op  input  OP_W  decoded instruction ID
in_npc  input  XLEN  PC+4 of the instruction
in_rs1  input  XLEN  rs1 value
in_rs2  input  XLEN  rs2 value
in_imm  input  XLEN  sign-extended immediate
in_tag  input  TAG_W  ROB tag
flush  input  1  ROB mispredict flush
out_valid  output  1  result valid to CDB
out_ready  input  1  CDB grants this cycle
out_tag  output  TAG_W  ROB tag of the result
out_result  output  XLEN  rd write value
out_npc  output  XLEN  resolved next PC
out_jump  output  1  out_npc != in_npc (redirect required)

Behaviour:
- Reset (rst_in=1 at posedge): out_valid=0, out_tag=0, out_result=0, out_npc=0, out_jump=0, FSM=IDLE. Reset overrides rdy_in and flush.
- rdy_in=0: no register updates; in_ready=0.
- Handshake:
  - in_ready = rdy_in & FSM==IDLE & (!out_valid | out_ready).
  - Accept when in_valid & in_ready.
  - Output holds stable while out_valid & !out_ready.
  - Transfer completes when out_valid & out_ready.
- Latency: single-cycle ops give out_valid=1 on the cycle after accept.
  - Back-to-back accepts are permitted at full throughput when out_ready=1.
- Results, all arithmetic modulo 2^XLEN:
  - lui: imm.
  - auipc: npc-4+imm.
  - jal: result=npc, out_npc=npc-4+imm.
  - jalr: result=npc, out_npc=(rs1+imm)&~1.
  - Branches: result=0; out_npc=npc-4+imm if taken, else npc.
    - blt/bge compare signed; bltu/bgeu compare unsigned.
  - slt/slti: signed compare. sltu/sltiu: unsigned compare. Result is 0 or 1, zero-extended.
  - Shifts use shamt = low log2(XLEN) bits of rs2/imm.
    - sll/slli, srl/srli: logical. sra/srai: arithmetic.
  - add/addi, sub, xor/xori, or/ori, and/andi: standard.
  - Unknown op: result=0, out_npc=npc.
- out_jump = (out_npc != npc); registered together with the other outputs.
- FSM states IDLE, MUL, DONE. MUL and DONE are only reachable with ALU_MUL_EN.
  - Without ALU_MUL_EN the unit stays in IDLE.
- Flush (flush=1 at posedge, rst_in=0, rdy_in=1):
  - out_valid←0 and FSM←IDLE.
  - Any in-flight multiply is discarded.
  - An instruction offered in the same cycle is not accepted: in_ready is forced low while flush=1.
- Flush coinciding with out_ready=1: the transfer does not count and the result is dropped.
- Result and transfer in the same cycle: a new result may load in the same cycle the old one transfers. No bubble.

Optional Feature:
- ALU_MUL_EN defined:
  - Decoder enumerators Instmul, Instmulh, Instmulhsu and Instmulhu are executed.
  - Accept moves IDLE→MUL and in_ready goes to 0.
  - A 2*XLEN-bit shift-add accumulator runs one bit per cycle for XLEN cycles, with operands sign- or zero-extended per op.
  - MUL→DONE then sets out_valid, giving latency XLEN+1 cycles.
  - DONE→IDLE on transfer.
  - mul returns the low XLEN bits; mulh, mulhsu and mulhu return the high XLEN bits.
- ALU_MUL_EN undefined: those IDs are treated as unknown ops (result 0, single cycle) and the multiplier logic is absent.

Test Plan:
- Reset then addi rs1=5, imm=-3 (0xFFFFFFFD), tag=2 → next cycle out_valid=1, result=2, tag=2, out_jump=0.
- sltu rs1=0xFFFFFFFF, rs2=1 → result=0. srl rs1=0x80000000, rs2=0x21 → result=0x40000000 (shamt=1). sra on the same operands → result=0xC0000000.
- beq npc=0x104, imm=0x20, rs1=rs2=7 → out_npc=0x120, out_jump=1. With rs1=7, rs2=8 → out_npc=0x104, out_jump=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. out_ready=1 → transfer, and the next op is accepted the same cycle.
- Flush while out_valid=1 and out_ready=0 → out_valid=0 next cycle. Flush and in_valid in the same cycle → nothing accepted.
- ALU_MUL_EN: mulh 0xFFFFFFFE × 3 → out_valid after 33 cycles, result=0xFFFFFFFF. mulhu on the same operands → result=2. Flush at cycle 10 → no output, in_ready=1 next cycle.
